// File: rtl/snake_vga_renderer.sv
// VGA raster stage for the snake game: timing, per-frame coordinate snapshot, cell colouring.
// Define SNAKE_GRID_LINES_EN to draw dim grid lines on empty cells.
module snake_vga_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_SHIFT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] snake_x,
    input  logic [7:0] snake_y,
    input  logic [7:0] fruit_x,
    input  logic [7:0] fruit_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [7:0] color_R,
    output logic [7:0] color_G,
    output logic [7:0] color_B,
    output logic       frame_tick
);

    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] COL_END = 8'((H_ACTIVE >> CELL_SHIFT) - 1);
    localparam logic [7:0] ROW_END = 8'((V_ACTIVE >> CELL_SHIFT) - 1);
    localparam logic [9:0] SUB_MSK = 10'((1 << CELL_SHIFT) - 1);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [7:0]  snake_x_q;
    logic [7:0]  snake_y_q;
    logic [7:0]  fruit_x_q;
    logic [7:0]  fruit_y_q;
    logic        active;
    logic        hsync_s;
    logic        vsync_s;
    logic        latch;
    logic [7:0]  cell_x;
    logic [7:0]  cell_y;
    logic        is_snake;
    logic        is_fruit;
    logic        is_border;
    logic        is_grid;
    logic [23:0] rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_s = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vsync_s = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign latch   = (h_cnt == '0) && (v_cnt == V_ACT);

    assign frame_tick = latch;

    // Snapshot once per frame, at the first blanking line, so drawing never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snake_x_q <= '0;
            snake_y_q <= '0;
            fruit_x_q <= '0;
            fruit_y_q <= '0;
        end else if (latch) begin
            snake_x_q <= snake_x;
            snake_y_q <= snake_y;
            fruit_x_q <= fruit_x;
            fruit_y_q <= fruit_y;
        end
    end

    assign cell_x = 8'(h_cnt >> CELL_SHIFT);
    assign cell_y = 8'(v_cnt >> CELL_SHIFT);

    assign is_snake  = (cell_x == snake_x_q) && (cell_y == snake_y_q);
    assign is_fruit  = (cell_x == fruit_x_q) && (cell_y == fruit_y_q);
    assign is_border = (cell_x == 8'd0) || (cell_y == 8'd0) ||
                       (cell_x == COL_END) || (cell_y == ROW_END);
    assign is_grid   = ((h_cnt & SUB_MSK) == '0) || ((v_cnt & SUB_MSK) == '0);

    always_comb begin
        rgb = 24'h000000;
        if (!active)
            rgb = 24'h000000;
        else if (is_snake && is_fruit)
            rgb = 24'hFFFF00;
        else if (is_snake)
            rgb = 24'h00FF00;
        else if (is_fruit)
            rgb = 24'hFF0000;
        else if (is_border)
            rgb = 24'h808080;
`ifdef SNAKE_GRID_LINES_EN
        else if (is_grid)
            rgb = 24'h202020;
`else
        else if (is_grid)
            rgb = 24'h000000;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            color_R  <= '0;
            color_G  <= '0;
            color_B  <= '0;
        end else begin
            hsync    <= hsync_s;
            vsync    <= vsync_s;
            video_on <= active;
            pixel_x  <= h_cnt;
            pixel_y  <= v_cnt;
            color_R  <= rgb[23:16];
            color_G  <= rgb[15:8];
            color_B  <= rgb[7:0];
        end
    end

endmodule

// File: tb/tb_snake_vga_renderer.sv
// Directed bench for snake_vga_renderer on a reduced raster (80x55 clocks/frame).
// Expected values follow from the geometry: output after edge n shows counter state n-1.
module tb_snake_vga_renderer;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk;
    logic       rst;
    logic [7:0] snake_x, snake_y, fruit_x, fruit_y;
    logic       hsync, vsync, video_on, frame_tick;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] color_R, color_G, color_B;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    snake_vga_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SHIFT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .snake_x(snake_x), .snake_y(snake_y),
        .fruit_x(fruit_x), .fruit_y(fruit_y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .color_R(color_R), .color_G(color_G), .color_B(color_B),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_to(input int target);
        if (cyc < target) begin
            while (cyc < target) begin
                @(posedge clk);
                cyc++;
            end
            @(negedge clk);
        end
    endtask

    task automatic pix(input string tag, input int f, input int x,
                       input int y, input logic [23:0] exp_rgb,
                       input logic exp_von);
        run_to(f * FT + y * HT + x + 1);
        check({tag, "_rgb"}, {8'h0, color_R, color_G, color_B}, {8'h0, exp_rgb});
        check({tag, "_von"}, 32'(video_on), 32'(exp_von));
        check({tag, "_px"}, 32'(pixel_x), 32'(x));
        check({tag, "_py"}, 32'(pixel_y), 32'(y));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hs"}, 32'(hsync), 32'd1);
        check({tag, "_vs"}, 32'(vsync), 32'd1);
        check({tag, "_von"}, 32'(video_on), 32'd0);
        check({tag, "_rgb"}, {8'h0, color_R, color_G, color_B}, 32'h0);
        check({tag, "_pxy"}, {12'h0, pixel_x, pixel_y}, 32'h0);
        check({tag, "_tick"}, 32'(frame_tick), 32'd0);
    endtask

    int hs_low, vs_low, ticks, first_fall;
    logic hs_prev;

    initial begin
        rst = 1'b1;
        snake_x = 8'd2; snake_y = 8'd1;
        fruit_x = 8'd5; fruit_y = 8'd4;
        @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        cyc = 0;

        // frame 0 draws with reset coordinates (0,0): both objects overlap
        pix("f0_org", 0, 0, 0, 24'hFFFF00, 1'b1);
        pix("f0_brd", 0, 8, 0, 24'h808080, 1'b1);
        run_to(VA * HT);
        check("f0_tick_hi", 32'(frame_tick), 32'd1);
        run_to(VA * HT + 1);
        check("f0_tick_lo", 32'(frame_tick), 32'd0);

        pix("f1_org", 1, 0, 0, 24'h808080, 1'b1);
        pix("f1_snk0", 1, 16, 8, 24'h00FF00, 1'b1);
        pix("f1_rgt", 1, 24, 8, 24'h000000, 1'b1);
        pix("f1_blank", 1, 70, 10, 24'h000000, 1'b0);
        pix("f1_snk1", 1, 23, 15, 24'h00FF00, 1'b1);
        pix("f1_frt", 1, 40, 32, 24'hFF0000, 1'b1);
        pix("f1_corner", 1, 63, 47, 24'h808080, 1'b1);
        snake_x = 8'd3; snake_y = 8'd3;
        fruit_x = 8'd3; fruit_y = 8'd3;

        pix("f2_org", 2, 0, 0, 24'h808080, 1'b1);
        run_to(2 * FT + 20 * HT);
        snake_x = 8'd4;
        pix("f2_ovl0", 2, 24, 24, 24'hFFFF00, 1'b1);
        pix("f2_old", 2, 32, 24, 24'h000000, 1'b1);
        pix("f2_ovl1", 2, 31, 31, 24'hFFFF00, 1'b1);
        run_to(2 * FT + VA * HT);
        check("f2_tick", 32'(frame_tick), 32'd1);

        pix("f3_frt", 3, 24, 24, 24'hFF0000, 1'b1);
        pix("f3_snk", 3, 32, 24, 24'h00FF00, 1'b1);
        pix("f3_brd", 3, 63, 40, 24'h808080, 1'b1);
        rst = 1'b1;
        #1;
        check_reset("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        hs_low = 0; vs_low = 0; ticks = 0; first_fall = -1;
        hs_prev = hsync;
        for (int n = 1; n <= 2 * FT; n++) begin
            run_to(n);
            if (n == 1)
                check("rst_org", {8'h0, color_R, color_G, color_B}, 32'hFFFF00);
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_tick) ticks++;
            if (hs_prev && !hsync && first_fall < 0) first_fall = n;
            hs_prev = hsync;
        end
        check("hs_fall", 32'(first_fall), 32'(HA + HF + 1));
        check("hs_low", 32'(hs_low), 32'(2 * VT * HS));
        check("vs_low", 32'(vs_low), 32'(2 * VS * HT));
        check("ticks", 32'(ticks), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
